// File: rtl/multicycle_ctrl_if.sv
// Bundle of signals between the multi-cycle control unit and the datapath.
// The master side is the controller. The slave side is the datapath (IR, ALU flags, memory).
interface multicycle_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [OP_W-1:0]    instr_op_i;
    logic               zero_i;
    logic               mem_ready_i;

    logic               pc_write_o;
    logic               ir_write_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               reg_write_o;
    logic               iord_o;
    logic               alu_src_a_o;
    logic               branch_o;
    logic               branch_type_o;
    logic [1:0]         alu_src_b_o;
    logic [1:0]         pc_src_o;
    logic [1:0]         reg_dst_o;
    logic [1:0]         mem_to_reg_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic [2:0]         state_o;
    logic               illegal_o;
    logic               timeout_o;
    logic [CNT_W-1:0]   instr_cnt_o;

    modport master (
        input  instr_op_i, zero_i, mem_ready_i,
        output pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
               iord_o, alu_src_a_o, branch_o, branch_type_o, alu_src_b_o,
               pc_src_o, reg_dst_o, mem_to_reg_o, alu_op_o, state_o,
               illegal_o, timeout_o, instr_cnt_o
    );

    modport slave (
        output instr_op_i, zero_i, mem_ready_i,
        input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
               iord_o, alu_src_a_o, branch_o, branch_type_o, alu_src_b_o,
               pc_src_o, reg_dst_o, mem_to_reg_o, alu_op_o, state_o,
               illegal_o, timeout_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control unit. A registered FETCH/DECODE/EXEC/MEM/WB sequencer
// drives combinational datapath controls from the IR opcode. It also handles
// memory wait states with a timeout, flags illegal opcodes, and counts retired
// instructions.
module multicycle_ctrl #(
    parameter int OP_W     = 6,
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_R    = 6'b111111;
    localparam logic [5:0] OP_ADDI = 6'b110111;
    localparam logic [5:0] OP_LW   = 6'b100001;
    localparam logic [5:0] OP_SW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b111011;
    localparam logic [5:0] OP_BNE  = 6'b100101;
    localparam logic [5:0] OP_J    = 6'b100010;
    localparam logic [5:0] OP_JAL  = 6'b100111;

    // The wait counter only has to reach MAX_WAIT-1 before the timeout clears it.
    localparam int                WAIT_W    = $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [2:0]         state, state_next;
    logic [WAIT_W-1:0]  wait_cnt, wait_next;
    logic [CNT_W-1:0]   instr_cnt;
    logic [OP_W-1:0]    op_full;
    logic [5:0]         op;
    logic               ready, waiting, timeout, retire;

    logic               pc_write, ir_write, mem_read, mem_write, reg_write;
    logic               iord, alu_src_a, branch, branch_type, illegal;
    logic [1:0]         alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;

    assign op_full = bus.instr_op_i;
    assign op      = op_full[5:0];
    assign ready   = bus.mem_ready_i;

    // A wait cycle is a FETCH or MEM cycle in which memory has not finished.
    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !ready;
    assign timeout = waiting && (wait_cnt == WAIT_LAST);

    // Per-state control decode, next-state selection and retirement detection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next  = state;
        retire      = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        iord        = 1'b0;
        alu_src_a   = 1'b0;
        branch      = 1'b0;
        branch_type = 1'b0;
        illegal     = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        alu_op      = '0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // The ALU computes the branch target speculatively.
                alu_src_b = 2'b11;
                case (op)
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_next = S_EXEC;
                    OP_J: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (op)
                    OP_R: begin
                        alu_op     = ALUOP_W'(3'b010);
                        state_next = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src_b  = 2'b10;
                        alu_op     = ALUOP_W'(3'b100);
                        state_next = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b  = 2'b10;
                        state_next = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        branch      = 1'b1;
                        branch_type = (op == OP_BNE);
                        alu_op      = (op == OP_BNE) ? ALUOP_W'(3'b110) : ALUOP_W'(3'b001);
                        pc_src      = 2'b01;
                        pc_write    = (op == OP_BNE) ? !bus.zero_i : bus.zero_i;
                        retire      = 1'b1;
                        state_next  = S_FETCH;
                    end
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (op == OP_LW);
                mem_write = (op == OP_SW);
                if (ready) begin
                    retire     = (op == OP_SW);
                    state_next = (op == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op == OP_R)  ? 2'b01 : 2'b00;
                mem_to_reg = (op == OP_LW) ? 2'b01 : 2'b00;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // A timeout only occurs on a not-ready cycle, so no write or retirement is pending here.
        if (timeout) state_next = S_FETCH;
    end

    assign wait_next = (waiting && !timeout) ? wait_cnt + WAIT_W'(1) : '0;

    // State, wait counter and retired-instruction counter, with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_i) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // While reset is held, every output is forced to zero, so an aborted instruction writes nothing.
    assign bus.pc_write_o    = rst_i & pc_write;
    assign bus.ir_write_o    = rst_i & ir_write;
    assign bus.mem_read_o    = rst_i & mem_read;
    assign bus.mem_write_o   = rst_i & mem_write;
    assign bus.reg_write_o   = rst_i & reg_write;
    assign bus.iord_o        = rst_i & iord;
    assign bus.alu_src_a_o   = rst_i & alu_src_a;
    assign bus.branch_o      = rst_i & branch;
    assign bus.branch_type_o = rst_i & branch_type;
    assign bus.illegal_o     = rst_i & illegal;
    assign bus.timeout_o     = rst_i & timeout;
    assign bus.alu_src_b_o   = rst_i ? alu_src_b  : 2'b00;
    assign bus.pc_src_o      = rst_i ? pc_src     : 2'b00;
    assign bus.reg_dst_o     = rst_i ? reg_dst    : 2'b00;
    assign bus.mem_to_reg_o  = rst_i ? mem_to_reg : 2'b00;
    assign bus.alu_op_o      = rst_i ? alu_op     : '0;
    assign bus.state_o       = rst_i ? state      : S_FETCH;
    assign bus.instr_cnt_o   = rst_i ? instr_cnt  : '0;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. The stimulus process walks instructions
// through their phases. It builds each cycle's expected control word from the
// instruction-level rules. A compare process checks the DUT on every falling edge.
module tb_multicycle_ctrl;
    localparam int MAX_WAIT = 4;

    localparam logic [5:0] OP_R    = 6'b111111;
    localparam logic [5:0] OP_ADDI = 6'b110111;
    localparam logic [5:0] OP_LW   = 6'b100001;
    localparam logic [5:0] OP_SW   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b111011;
    localparam logic [5:0] OP_BNE  = 6'b100101;
    localparam logic [5:0] OP_J    = 6'b100010;
    localparam logic [5:0] OP_JAL  = 6'b100111;

    typedef struct packed {
        logic       pc_write, ir_write, mem_read, mem_write, reg_write;
        logic       iord, alu_src_a, branch, branch_type, illegal, timeout;
        logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
        logic [2:0] alu_op, state;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    ctl_t        exp_now;
    logic [31:0] exp_cnt;
    bit          exp_valid = 1'b0;
    logic [31:0] model_cnt = '0;

    // Observations gathered by the compare process for the directed literal checks.
    logic [31:0] st_trace = '0;
    logic [31:0] pcw_trace = '0;
    int          ill_cnt = 0;
    int          mw_cycles = 0;
    int          to_cnt = 0;

    multicycle_ctrl_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(32)) bus ();

    multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .MAX_WAIT(MAX_WAIT), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: each falling edge, check the DUT outputs against the current expectation.
    initial begin
        ctl_t a;
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                a.pc_write    = bus.pc_write_o;
                a.ir_write    = bus.ir_write_o;
                a.mem_read    = bus.mem_read_o;
                a.mem_write   = bus.mem_write_o;
                a.reg_write   = bus.reg_write_o;
                a.iord        = bus.iord_o;
                a.alu_src_a   = bus.alu_src_a_o;
                a.branch      = bus.branch_o;
                a.branch_type = bus.branch_type_o;
                a.illegal     = bus.illegal_o;
                a.timeout     = bus.timeout_o;
                a.alu_src_b   = bus.alu_src_b_o;
                a.pc_src      = bus.pc_src_o;
                a.reg_dst     = bus.reg_dst_o;
                a.mem_to_reg  = bus.mem_to_reg_o;
                a.alu_op      = bus.alu_op_o;
                a.state       = bus.state_o;
                check("ctl", {7'd0, a}, {7'd0, exp_now});
                check("instr_cnt", bus.instr_cnt_o, exp_cnt);
                st_trace = {st_trace[27:0], 1'b0, bus.state_o};
                if (bus.state_o == 3'd2) pcw_trace = {pcw_trace[30:0], bus.pc_write_o};
                if (bus.illegal_o) ill_cnt++;
                if (bus.mem_write_o) mw_cycles++;
                if (bus.timeout_o) to_cnt++;
            end
        end
    end

    // Publish one cycle's expectation, then advance past the next rising edge.
    task automatic step(input ctl_t e);
        exp_now   = e;
        exp_cnt   = model_cnt;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_cnt = '0;
        for (int i = 0; i < n; i++) begin
            bus.instr_op_i  = 6'($urandom);
            bus.zero_i      = 1'($urandom);
            bus.mem_ready_i = 1'($urandom);
            step('0);
        end
        rst = 1'b1;
    endtask

    // Instruction-level model. fwait/mwait are the not-ready cycles before memory
    // completes in FETCH/MEM. A wait reaching MAX_WAIT cycles times out.
    task automatic run_instr(input logic [5:0] op, input logic zero, input int fwait,
                             input int mwait, input bit rst_in_exec);
        ctl_t e;
        for (int i = 0; ; i++) begin
            bus.instr_op_i  = 6'($urandom);
            bus.zero_i      = 1'($urandom);
            bus.mem_ready_i = (i == fwait);
            e = '0;
            e.state = 3'd0;
            e.mem_read = 1'b1;
            e.alu_src_b = 2'b01;
            if (i == fwait) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
                step(e);
                break;
            end
            if (i == MAX_WAIT - 1) begin
                e.timeout = 1'b1;
                step(e);
                return;
            end
            step(e);
        end

        bus.instr_op_i  = op;
        bus.zero_i      = 1'($urandom);
        bus.mem_ready_i = 1'($urandom);
        e = '0;
        e.state = 3'd1;
        e.alu_src_b = 2'b11;
        case (op)
            OP_J, OP_JAL: begin
                e.pc_write = 1'b1;
                e.pc_src = 2'b10;
                if (op == OP_JAL) begin
                    e.reg_write = 1'b1;
                    e.reg_dst = 2'b10;
                    e.mem_to_reg = 2'b10;
                end
                step(e);
                model_cnt++;
                return;
            end
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: step(e);
            default: begin
                e.illegal = 1'b1;
                step(e);
                return;
            end
        endcase

        bus.zero_i      = zero;
        bus.mem_ready_i = 1'($urandom);
        if (rst_in_exec) begin
            rst = 1'b0;
            model_cnt = '0;
            step('0);
            rst = 1'b1;
            return;
        end
        e = '0;
        e.state = 3'd2;
        e.alu_src_a = 1'b1;
        case (op)
            OP_R:         e.alu_op = 3'b010;
            OP_ADDI:      begin e.alu_src_b = 2'b10; e.alu_op = 3'b100; end
            OP_LW, OP_SW: e.alu_src_b = 2'b10;
            default: begin
                e.branch = 1'b1;
                e.pc_src = 2'b01;
                e.branch_type = (op == OP_BNE);
                e.alu_op = (op == OP_BNE) ? 3'b110 : 3'b001;
                e.pc_write = (op == OP_BNE) ? !zero : zero;
            end
        endcase
        step(e);
        if (op == OP_BEQ || op == OP_BNE) begin
            model_cnt++;
            return;
        end

        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; ; i++) begin
                bus.zero_i      = 1'($urandom);
                bus.mem_ready_i = (i == mwait);
                e = '0;
                e.state = 3'd3;
                e.iord = 1'b1;
                e.mem_read = (op == OP_LW);
                e.mem_write = (op == OP_SW);
                if (i != mwait && i == MAX_WAIT - 1) begin
                    e.timeout = 1'b1;
                    step(e);
                    return;
                end
                step(e);
                if (i == mwait) begin
                    if (op == OP_SW) begin
                        model_cnt++;
                        return;
                    end
                    break;
                end
            end
        end

        bus.zero_i      = 1'($urandom);
        bus.mem_ready_i = 1'($urandom);
        e = '0;
        e.state = 3'd4;
        e.reg_write = 1'b1;
        e.reg_dst = (op == OP_R) ? 2'b01 : 2'b00;
        e.mem_to_reg = (op == OP_LW) ? 2'b01 : 2'b00;
        step(e);
        model_cnt++;
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
        bus.instr_op_i  = '0;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b0;
        @(posedge clk);
        #1;

        do_reset(2);
        check("reset_state", {29'd0, bus.state_o}, 32'd0);

        // lw with memory always ready: full five-state walk, one retirement.
        st_trace = '0;
        run_instr(OP_LW, 1'b0, 0, 0, 1'b0);
        check("lw_states", st_trace, 32'h0001_2340 >> 4);
        check("lw_cnt", bus.instr_cnt_o, 32'd1);
        check("lw_model_cnt", model_cnt, 32'd1);

        // beq then bne, both with zero set: only the first writes the PC.
        pcw_trace = '0;
        run_instr(OP_BEQ, 1'b1, 0, 0, 1'b0);
        run_instr(OP_BNE, 1'b1, 0, 0, 1'b0);
        check("branch_pc_write", pcw_trace, 32'b10);
        check("branch_cnt", bus.instr_cnt_o, 32'd3);

        // jal completes in two cycles.
        st_trace = '0;
        run_instr(OP_JAL, 1'b0, 0, 0, 1'b0);
        check("jal_states", st_trace, 32'h01);
        check("jal_back_fetch", {29'd0, bus.state_o}, 32'd0);

        // Illegal opcode pulses once and does not retire.
        run_instr(6'b000000, 1'b0, 0, 0, 1'b0);
        check("illegal_pulses", ill_cnt, 32'd1);
        check("illegal_cnt", bus.instr_cnt_o, 32'd4);

        // sw waiting 3 cycles in MEM (the last allowed wait before timeout).
        mw_cycles = 0;
        run_instr(OP_SW, 1'b0, 0, 3, 1'b0);
        check("sw_write_cycles", mw_cycles, 32'd4);
        check("sw_cnt", bus.instr_cnt_o, 32'd5);

        // Timeouts in MEM and in FETCH: no retirement, back to FETCH.
        run_instr(OP_LW, 1'b0, 0, 99, 1'b0);
        run_instr(OP_R, 1'b0, 99, 0, 1'b0);
        check("timeout_pulses", to_cnt, 32'd2);
        check("timeout_cnt", bus.instr_cnt_o, 32'd5);
        check("timeout_fetch", {29'd0, bus.state_o}, 32'd0);

        // Reset during EXEC of an R-type aborts it.
        run_instr(OP_R, 1'b0, 0, 0, 1'b1);
        check("abort_state", {29'd0, bus.state_o}, 32'd0);
        check("abort_cnt", bus.instr_cnt_o, 32'd0);

        // Randomized instruction stream with occasional illegal opcodes and long waits.
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [5:0] op;
            int fw, mw;
            k  = $urandom_range(0, 9);
            op = (k < 8) ? ops[k] : 6'($urandom);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
            mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
            run_instr(op, 1'($urandom), fw, mw, ($urandom_range(0, 49) == 0));
        end

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
